// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction size and byte order.
// Imported by the fetch unit and the decoder.
package cpu_pkg;

  // Bytes per instruction; the instruction register must use the same count.
  localparam int INST_BYTES = 3;

  // Byte order within an instruction, in fetch order.
  localparam int OPCODE_IDX     = 0;
  localparam int OPERAND_HI_IDX = 1;
  localparam int OPERAND_LO_IDX = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_RDY = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Program-memory read port and instruction-register load port of the fetch unit.
// The master side is the fetch unit; the slave side is memory plus the register.
interface instruction_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              IR_load;
  logic [7:0]        payload;
  logic              ready_flag;

  modport master (
    output mem_rd, mem_addr, IR_load, payload,
    input  mem_data, ready_flag
  );

  modport slave (
    input  mem_rd, mem_addr, IR_load, payload,
    output mem_data, ready_flag
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: streams INST_BYTES program bytes into the instruction
// register, then waits for its ReadyFlag. Define FETCH_TIMEOUT_EN for a WAIT_RDY watchdog.
module instruction_fetch #(
  parameter int ADDR_W     = 8,
  parameter int INST_BYTES = cpu_pkg::INST_BYTES,
  parameter int TIMEOUT    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_req,
  input  logic                 branch_req,
  input  logic [ADDR_W-1:0]    branch_addr,
  instruction_fetch_if.master  bus,
  output logic [ADDR_W-1:0]    pc,
  output logic [ADDR_W-1:0]    inst_addr,
  output logic                 busy,
  output logic                 fetch_done,
  output logic                 fetch_err
);
  import cpu_pkg::*;

  localparam int CNT_W = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
  localparam logic [CNT_W-1:0] FIRST_BYTE = CNT_W'(OPCODE_IDX);
  localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(INST_BYTES - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              ir_load_q, ir_load_d;
  logic              fetch_done_q, fetch_done_d;
  logic              mem_rd;

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            fetch_err_q, fetch_err_d;
`else
  localparam int timeout_unused = TIMEOUT;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_addr_d  = inst_addr_q;
    byte_cnt_d   = byte_cnt_q;
    fetch_done_d = 1'b0;
    mem_rd       = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    // Watchdog holds at zero outside WAIT_RDY, so it restarts on every entry.
    wd_cnt_d     = '0;
    fetch_err_d  = fetch_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (branch_req) begin
          pc_d = branch_addr;
        end
        // A simultaneous branch supplies the start address of this fetch.
        if (fetch_req) begin
          inst_addr_d = branch_req ? branch_addr : pc_q;
          byte_cnt_d  = FIRST_BYTE;
          state_d     = FETCH;
        end
      end

      FETCH: begin
        mem_rd     = 1'b1;
        pc_d       = pc_q + 1'b1;
        byte_cnt_d = byte_cnt_q + 1'b1;
        if (byte_cnt_q == LAST_BYTE) begin
          state_d = WAIT_RDY;
        end
      end

      WAIT_RDY: begin
        if (ready_flag_in()) begin
          fetch_done_d = 1'b1;
          state_d      = IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT)) begin
          fetch_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data arrives one cycle after the strobe, so the load follows it by one cycle.
  assign ir_load_d = mem_rd;

  function automatic logic ready_flag_in();
    return bus.ready_flag;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      inst_addr_q  <= '0;
      byte_cnt_q   <= '0;
      ir_load_q    <= 1'b0;
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_addr_q  <= inst_addr_d;
      byte_cnt_q   <= byte_cnt_d;
      ir_load_q    <= ir_load_d;
      fetch_done_q <= fetch_done_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q    <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wd_cnt_q    <= wd_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign bus.mem_rd   = mem_rd;
  assign bus.mem_addr = pc_q;
  assign bus.IR_load  = ir_load_q;
  assign bus.payload  = bus.mem_data;

  assign pc         = pc_q;
  assign inst_addr  = inst_addr_q;
  assign busy       = (state_q != IDLE);
  assign fetch_done = fetch_done_q;

endmodule
